// File: rtl/seq_counter.sv
// Start-triggered up/down sequencing counter with enable, abort and
// saturating or modulo-2^WIDTH stepping toward a latched terminal value.
module seq_counter #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             abort,
    input  logic             dir,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    state_t           state;
    logic             dir_q;
    logic [WIDTH-1:0] term_q;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH:0]   nxt;
    logic             hit;

    // nxt carries the carry (up) or borrow (down) in its top bit
    always_comb begin
        tgt = dir_q ? '0 : term_q;
        nxt = dir_q ? ({1'b0, count} - STEP_X)
                    : ({1'b0, count} + STEP_X);
        hit = 1'b0;
        if (SAT) begin
            if (dir_q)
                hit = nxt[WIDTH] || (nxt[WIDTH-1:0] == '0);
            else
                hit = (nxt >= {1'b0, term_q});
        end else begin
            hit = (nxt[WIDTH-1:0] == tgt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            ovf    <= 1'b0;
            dir_q  <= 1'b0;
            term_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dir_q  <= dir;
                        term_q <= term_val;
                        count  <= dir ? term_val : '0;
                        ovf    <= 1'b0;
                        // loaded value equals target only when term is 0
                        state  <= (term_val == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (en) begin
                        if (SAT) begin
                            if (hit) begin
                                count <= tgt;
                                state <= FIN;
                            end else begin
                                count <= nxt[WIDTH-1:0];
                            end
                        end else begin
                            count <= nxt[WIDTH-1:0];
                            if (nxt[WIDTH])
                                ovf <= 1'b1;
                            if (hit)
                                state <= FIN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == FIN);

endmodule
